// File: rtl/sram_port_arbiter.sv
// Two-port round-robin arbiter with bounded lock in front of a single-port, byte-enabled SRAM macro.
// Define SRAM_ARB_STATS_EN to add saturating per-port grant counters and a conflict counter.
module sram_port_arbiter #(
   parameter logic [32:0] MEM_BYTES = 33'h0_0400_0000,
   parameter int unsigned MAX_LOCK  = 8
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic [1:0]  req_i,
   input  logic [1:0]  we_i,
   input  logic [1:0]  lock_i,
   input  logic [7:0]  be_i,
   input  logic [63:0] addr_i,
   input  logic [63:0] wdata_i,
   output logic [1:0]  gnt_o,
   output logic [1:0]  rsp_valid_o,
   output logic        rsp_err_o,
   output logic [31:0] rdata_o,
   output logic        sram_cen,
   output logic        sram_wen,
   output logic [3:0]  sram_ben,
   output logic [31:0] sram_addr,
   output logic [31:0] sram_din,
   input  logic [31:0] sram_dout
`ifdef SRAM_ARB_STATS_EN
   ,
   output logic [31:0] grant_cnt0_o,
   output logic [31:0] grant_cnt1_o,
   output logic [31:0] conflict_cnt_o
`endif
);

   localparam int unsigned CNT_W = $clog2(MAX_LOCK + 1);
   localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(MAX_LOCK);

   typedef enum logic [1:0] {ARB, HOLD0, HOLD1} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d, cnt_inc;
   logic              last_grant_q, last_grant_d;
   logic              grant, win, hold_port;
   logic [31:0]       sel_addr, sel_wdata;
   logic [3:0]        sel_be;
   logic              sel_we, in_range, gnt_eff, access;
   logic [31:0]       addr_hold_q, addr_hold_d, din_hold_q, din_hold_d;
   logic              rsp_valid_q, rsp_valid_d, rsp_port_q, rsp_port_d;
   logic              rsp_read_q, rsp_read_d, rsp_err_q, rsp_err_d;

   // A held port keeps winning while it requests; the lock counter counts consecutive grants including the entry grant.
   always_comb begin
      state_d      = state_q;
      lock_cnt_d   = lock_cnt_q;
      last_grant_d = last_grant_q;
      grant        = 1'b0;
      win          = 1'b0;
      hold_port    = (state_q == HOLD1);
      cnt_inc      = (lock_cnt_q >= LOCK_MAX) ? lock_cnt_q : lock_cnt_q + CNT_W'(1);
      if (state_q != ARB && req_i[hold_port]) begin
         grant = 1'b1;
         win   = hold_port;
         if (!lock_i[win] || (cnt_inc >= LOCK_MAX && req_i[~win])) begin
            state_d    = ARB;
            lock_cnt_d = '0;
         end else begin
            lock_cnt_d = cnt_inc;
         end
      end else begin
         state_d    = ARB;
         lock_cnt_d = '0;
         if (req_i != 2'b00) begin
            grant = 1'b1;
            win   = (req_i == 2'b11) ? ~last_grant_q : req_i[1];
            if (lock_i[win] && !(MAX_LOCK <= 1 && req_i[~win])) begin
               state_d    = win ? HOLD1 : HOLD0;
               lock_cnt_d = CNT_W'(1);
            end
         end
      end
      if (grant) last_grant_d = win;
   end

   always_comb begin
      sel_addr    = win ? addr_i[63:32]  : addr_i[31:0];
      sel_wdata   = win ? wdata_i[63:32] : wdata_i[31:0];
      sel_be      = win ? be_i[7:4]      : be_i[3:0];
      sel_we      = we_i[win];
      in_range    = ({1'b0, sel_addr} < MEM_BYTES);
      gnt_eff     = grant & ~HRESET;
      access      = gnt_eff & in_range;
      gnt_o       = gnt_eff ? (win ? 2'b10 : 2'b01) : 2'b00;
      sram_cen    = ~access;
      sram_wen    = access ? ~sel_we : 1'b1;
      sram_ben    = access ? ~sel_be : 4'hF;
      addr_hold_d = gnt_eff ? {sel_addr[31:2], 2'b00} : addr_hold_q;
      din_hold_d  = gnt_eff ? sel_wdata : din_hold_q;
      sram_addr   = addr_hold_d;
      sram_din    = din_hold_d;
      rsp_valid_d = gnt_eff;
      rsp_port_d  = win;
      rsp_read_d  = ~sel_we;
      rsp_err_d   = ~in_range;
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q      <= ARB;
         lock_cnt_q   <= '0;
         last_grant_q <= 1'b1;
         addr_hold_q  <= '0;
         din_hold_q   <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_port_q   <= 1'b0;
         rsp_read_q   <= 1'b0;
         rsp_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         lock_cnt_q   <= lock_cnt_d;
         last_grant_q <= last_grant_d;
         addr_hold_q  <= addr_hold_d;
         din_hold_q   <= din_hold_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_port_q   <= rsp_port_d;
         rsp_read_q   <= rsp_read_d;
         rsp_err_q    <= rsp_err_d;
      end
   end

   // The macro registers its read data, so the response stage simply forwards sram_dout for good reads.
   always_comb begin
      rsp_valid_o = (rsp_valid_q && !HRESET) ? (rsp_port_q ? 2'b10 : 2'b01) : 2'b00;
      rsp_err_o   = rsp_valid_q & rsp_err_q & ~HRESET;
      rdata_o     = (rsp_valid_q && rsp_read_q && !rsp_err_q && !HRESET) ? sram_dout : 32'h0;
   end

`ifdef SRAM_ARB_STATS_EN
   logic [31:0] grant_cnt0_q, grant_cnt0_d, grant_cnt1_q, grant_cnt1_d;
   logic [31:0] conflict_cnt_q, conflict_cnt_d;

   always_comb begin
      grant_cnt0_d   = grant_cnt0_q;
      grant_cnt1_d   = grant_cnt1_q;
      conflict_cnt_d = conflict_cnt_q;
      if (gnt_o[0] && grant_cnt0_q != 32'hFFFF_FFFF) grant_cnt0_d = grant_cnt0_q + 32'd1;
      if (gnt_o[1] && grant_cnt1_q != 32'hFFFF_FFFF) grant_cnt1_d = grant_cnt1_q + 32'd1;
      if (req_i == 2'b11 && conflict_cnt_q != 32'hFFFF_FFFF) conflict_cnt_d = conflict_cnt_q + 32'd1;
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         grant_cnt0_q   <= '0;
         grant_cnt1_q   <= '0;
         conflict_cnt_q <= '0;
      end else begin
         grant_cnt0_q   <= grant_cnt0_d;
         grant_cnt1_q   <= grant_cnt1_d;
         conflict_cnt_q <= conflict_cnt_d;
      end
   end

   assign grant_cnt0_o   = grant_cnt0_q;
   assign grant_cnt1_o   = grant_cnt1_q;
   assign conflict_cnt_o = conflict_cnt_q;
`endif

endmodule
